seg_scan_mux: RTL



---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_scan_mux_if.sv | 27 ++
 rtl/seg_scan_timer.sv | 28 ++
 rtl/seg_scan_mux.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared segment-display definitions: active-low {g,f,e,d,c,b,a} encodings,
// scan FSM states and a helper that extracts one digit slice from a packed bus.
package seg_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  // Widest digit bus the slice helper accepts; narrower buses are padded with SEG_OFF.
  localparam int SEG_MAX_DIGITS = 32;
  localparam int SEG_IDX_W      = 5;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } scan_state_t;

  function automatic logic [6:0] slice_digit(
    input logic [7*SEG_MAX_DIGITS-1:0] bus,
    input logic [SEG_IDX_W-1:0]        idx
  );
    return bus[7*idx +: 7];
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-side bundle of the scan multiplexer: digit buses and enable in,
// shared segment bus, anode selects and frame pulse out.
interface seg_scan_mux_if #(
  parameter int N_DIGITS = 6
);
  logic                    enable;
  logic [7*N_DIGITS-1:0]   seg_in;
  logic [6:0]              seg_out;
  logic [N_DIGITS-1:0]     an;
  logic                    frame_done;

  modport master (
    output enable,
    output seg_in,
    input  seg_out,
    input  an,
    input  frame_done
  );

  modport slave (
    input  enable,
    input  seg_in,
    output seg_out,
    output an,
    output frame_done
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Loadable down-counter shared by the BLANK and SHOW phases; tc is high while
// the count sits at zero, i.e. during the last cycle of the loaded interval.
module seg_scan_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         count_en,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes N_DIGITS segment buses onto one registered bus with active-low
// anodes and dead-time blanking. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  seg_scan_mux_if.slave   bus
);

  localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int TMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] BLANK_LOAD = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] SCAN_LOAD  = TW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);

  scan_state_t          state_reg, state_next;
  logic [IW-1:0]        idx_reg, idx_next;
  logic [6:0]           seg_reg, seg_next;
  logic [N_DIGITS-1:0]  an_reg, an_next;
  logic                 frame_done_reg, frame_done_next;

  logic                 timer_load;
  logic                 timer_count_en;
  logic [TW-1:0]        timer_load_value;
  logic                 timer_tc;

  logic [7*SEG_MAX_DIGITS-1:0] seg_wide;
  logic [6:0]                  digit_seg;
  logic [N_DIGITS-1:0]         digit_an;
  logic                        suppress;

  seg_scan_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .count_en   (timer_count_en),
    .load_value (timer_load_value),
    .tc         (timer_tc)
  );

  always_comb begin
    seg_wide                   = '1;
    seg_wide[7*N_DIGITS-1:0]   = bus.seg_in;
  end

  assign digit_seg = slice_digit(seg_wide, SEG_IDX_W'(idx_reg));
  assign digit_an  = ~(N_DIGITS'(1) << idx_reg);

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] is_zero;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_zero
    assign is_zero[gi] = (bus.seg_in[7*gi +: 7] == SEG_ZERO);
  end

  // A digit is blanked only when it and every more significant digit read zero.
  always_comb begin
    suppress = (idx_reg != '0);
    for (int j = 0; j < N_DIGITS; j++) begin
      if ((IW'(j) >= idx_reg) && !is_zero[j]) begin
        suppress = 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    seg_next         = seg_reg;
    an_next          = an_reg;
    frame_done_next  = 1'b0;
    timer_load       = 1'b0;
    timer_count_en   = 1'b0;
    timer_load_value = BLANK_LOAD;

    if (!bus.enable) begin
      state_next       = IDLE;
      idx_next         = '0;
      seg_next         = SEG_OFF;
      an_next          = '1;
      timer_load       = 1'b1;
      timer_load_value = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = BLANK;
          idx_next   = '0;
          seg_next   = SEG_OFF;
          an_next    = '1;
          timer_load = 1'b1;
        end
        BLANK: begin
          if (timer_tc) begin
            state_next       = SHOW;
            timer_load       = 1'b1;
            timer_load_value = SCAN_LOAD;
            // Suppressed slots keep their timing but stay dark.
            if (suppress) begin
              seg_next = SEG_OFF;
              an_next  = '1;
            end else begin
              seg_next = digit_seg;
              an_next  = digit_an;
            end
          end else begin
            timer_count_en = 1'b1;
          end
        end
        SHOW: begin
          if (timer_tc) begin
            state_next      = BLANK;
            timer_load      = 1'b1;
            seg_next        = SEG_OFF;
            an_next         = '1;
            frame_done_next = (idx_reg == LAST_IDX);
            idx_next        = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
          end else begin
            timer_count_en = 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
          seg_next   = SEG_OFF;
          an_next    = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      seg_reg        <= SEG_OFF;
      an_reg         <= '1;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      seg_reg        <= seg_next;
      an_reg         <= an_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign bus.seg_out    = seg_reg;
  assign bus.an         = an_reg;
  assign bus.frame_done = frame_done_reg;

endmodule
